// File: rtl/spi_reg_target.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_target
// Description : SPI mode-0 target exposing a byte-wide register file.
//               SCLK/SSEL/MOSI are oversampled in the clk domain, and all
//               shifting and decoding is done with clk-domain edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_target #(
  parameter int NUM_REGS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  ssel,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr,
  output logic [7:0]            wr_data
);

  localparam int         c_aw       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] c_num_regs = 8'(NUM_REGS);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_cmd  = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;

  // Pin synchronizers; bit [1] is the synchronized value.
  logic [1:0] r_sclk_sync;
  logic [1:0] r_ssel_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sclk_prev;

  logic [1:0] r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift_in;
  logic [7:0] r_shift_out;
  logic [6:0] r_addr;
  logic       r_rd;
  logic       r_load_pend;

  logic [7:0] r_regs [NUM_REGS];
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic       w_sclk;
  logic       w_ssel;
  logic       w_mosi;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_byte;
  logic       w_in_range;
  logic [7:0] w_rd_data;
  logic       w_commit;

  // Two-flop synchronizers plus a delayed SCLK copy for edge detection.
  // SSEL resets high so the target comes out of reset deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= 2'b00;
      r_ssel_sync <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], sclk};
      r_ssel_sync <= {r_ssel_sync[0], ssel};
      r_mosi_sync <= {r_mosi_sync[0], mosi};
      r_sclk_prev <= r_sclk_sync[1];
    end
  end

  assign w_sclk = r_sclk_sync[1];
  assign w_ssel = r_ssel_sync[1];
  assign w_mosi = r_mosi_sync[1];
  assign w_rise = w_sclk & ~r_sclk_prev;
  assign w_fall = ~w_sclk & r_sclk_prev;

  // Byte as it will stand once the current rise's bit is shifted in.
  assign w_byte     = {r_shift_in, w_mosi};
  assign w_in_range = ({1'b0, r_addr} < c_num_regs);
  assign w_rd_data  = w_in_range ? r_regs[r_addr[c_aw-1:0]] : 8'h00;
  assign w_commit   = (r_state == c_st_data) && w_rise && (r_bit_cnt == 3'd7) && !r_rd;

  // Transaction FSM: command decode, bit counting, address tracking and the
  // MISO shift-out register. Deselect overrides everything except the write
  // commit, which is handled in the register-file block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_addr      <= 7'd0;
      r_rd        <= 1'b0;
      r_load_pend <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (!w_ssel) begin
            r_state   <= c_st_cmd;
            r_bit_cnt <= 3'd0;
          end
        end
        c_st_cmd: begin
          if (w_rise) begin
            r_shift_in <= w_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_addr      <= w_byte[6:0];
              r_rd        <= w_byte[7];
              r_load_pend <= w_byte[7];
              r_state     <= c_st_data;
            end
          end
        end
        c_st_data: begin
          if (w_rise) begin
            r_shift_in <= w_byte[6:0];
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_rd) begin
                r_load_pend <= 1'b1;
              end else begin
                r_addr <= r_addr + 7'd1;
              end
            end
          end
          // Reads reload on the fall after a byte boundary, else shift left.
          if (w_fall && r_rd) begin
            if (r_load_pend) begin
              r_shift_out <= w_rd_data;
              r_addr      <= r_addr + 7'd1;
              r_load_pend <= 1'b0;
            end else begin
              r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
          end
        end
        default: r_state <= c_st_idle;
      endcase

      if (w_ssel) begin
        r_state     <= c_st_idle;
        r_bit_cnt   <= 3'd0;
        r_shift_out <= 8'd0;
        r_load_pend <= 1'b0;
      end
    end
  end

  // Register file and write-report outputs; in-range writes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 8'd0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_commit && w_in_range) begin
        r_regs[r_addr[c_aw-1:0]] <= w_byte;
        r_wr_strobe              <= 1'b1;
        r_wr_addr                <= r_addr;
        r_wr_data                <= w_byte;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = r_regs[g];
  end

  assign miso      = r_shift_out[7];
  assign miso_oe   = ~w_ssel;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_target
// Description : Scoreboard bench for spi_reg_target (NUM_REGS = 8). Stimulus
//               queues expected writes and MISO bytes; monitors pop/compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_target;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        ssel;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [63:0] regs_flat;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;

  spi_reg_target #(.NUM_REGS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .ssel      (ssel),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic care; logic [7:0] v; } rd_t;

  wr_t exp_wr_q[$];
  rd_t exp_rd_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_strobe_unexpected: got addr %h data %h required no strobe", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_wr_q.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.a));
        check("wr_data", 64'(wr_data), 64'(e.d));
      end
    end
  end

  // MISO monitor: assemble bytes at SCLK rises while selected.
  logic [7:0] mon_sh = 8'h00;
  int         mon_n  = 0;
  always @(posedge sclk or posedge ssel) begin
    if (ssel) begin
      mon_n = 0;
    end else begin
      mon_sh = {mon_sh[6:0], miso};
      mon_n++;
      if (mon_n == 8) begin
        mon_n = 0;
        if (exp_rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL miso_unexpected_byte: got %h required none", mon_sh);
        end else begin
          rd_t e;
          e = exp_rd_q.pop_front();
          if (e.care) check("miso_byte", 64'(mon_sh), 64'(e.v));
        end
      end
    end
  end

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      #80 sclk = 1'b1;
      #80 sclk = 1'b0;
    end
  endtask

  task automatic frame_start();
    ssel = 1'b0;
    #80;
    check("miso_oe_selected", 64'(miso_oe), 64'd1);
  endtask

  task automatic frame_end();
    #80 ssel = 1'b1;
    #80;
    check("miso_oe_idle", 64'(miso_oe), 64'd0);
    check("miso_idle", 64'(miso), 64'd0);
  endtask

  task automatic cmd(input logic [7:0] c);
    rd_t r;
    r.care = 1'b1; r.v = 8'h00;
    exp_rd_q.push_back(r);
    send_bits(c, 8);
  endtask

  task automatic wbyte(input logic strobe_exp, input logic [6:0] a, input logic [7:0] d);
    rd_t r;
    wr_t w;
    r.care = 1'b0; r.v = 8'h00;
    exp_rd_q.push_back(r);
    if (strobe_exp) begin
      w.a = a; w.d = d;
      exp_wr_q.push_back(w);
    end
    send_bits(d, 8);
  endtask

  task automatic rbyte(input logic [7:0] exp_v, input logic [7:0] dummy);
    rd_t r;
    r.care = 1'b1; r.v = exp_v;
    exp_rd_q.push_back(r);
    send_bits(dummy, 8);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_regs_flat"}, regs_flat, 64'd0);
    check({tag, "_miso"}, 64'(miso), 64'd0);
    check({tag, "_miso_oe"}, 64'(miso_oe), 64'd0);
    check({tag, "_wr_strobe"}, 64'(wr_strobe), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    ssel  = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single write: reg5 <- A5
    frame_start(); cmd(8'h05); wbyte(1'b1, 7'd5, 8'hA5); frame_end();
    check("write_reg5", regs_flat, 64'h0000_A500_0000_0000);
    check("wr_addr_hold", 64'(wr_addr), 64'd5);
    check("wr_data_hold", 64'(wr_data), 64'hA5);

    // Preload reg3 then read it back
    frame_start(); cmd(8'h03); wbyte(1'b1, 7'd3, 8'h3C); frame_end();
    frame_start(); cmd(8'h83); rbyte(8'h3C, 8'hFF); frame_end();
    check("after_read_reg3", regs_flat, 64'h0000_A500_3C00_0000);

    // Burst write crossing the top of the register file
    frame_start(); cmd(8'h06);
    wbyte(1'b1, 7'd6, 8'h11); wbyte(1'b1, 7'd7, 8'h22); wbyte(1'b0, 7'd8, 8'h33);
    frame_end();
    check("burst_write", regs_flat, 64'h2211_A500_3C00_0000);

    // Abort mid-byte, then a normal write to the same register
    frame_start(); cmd(8'h02); send_bits(8'hFF, 5);
    #80 ssel = 1'b1;
    #80;
    check("abort_no_change", regs_flat, 64'h2211_A500_3C00_0000);
    frame_start(); cmd(8'h02); wbyte(1'b1, 7'd2, 8'h77); frame_end();
    check("write_after_abort", regs_flat, 64'h2211_A500_3C77_0000);

    // Out-of-range read, and a burst read with address increment
    frame_start(); cmd(8'hFF); rbyte(8'h00, 8'hA5); frame_end();
    frame_start(); cmd(8'h86); rbyte(8'h11, 8'h00); rbyte(8'h22, 8'hFF); frame_end();

    // Reset in the middle of a data byte
    frame_start(); cmd(8'h01); wbyte(1'b1, 7'd1, 8'h99); frame_end();
    check("write_reg1", regs_flat, 64'h2211_A500_3C77_9900);
    frame_start(); cmd(8'h01); send_bits(8'h55, 4);
    #20 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    ssel = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frame_start(); cmd(8'h04); wbyte(1'b1, 7'd4, 8'h42); frame_end();
    check("write_after_reset", regs_flat, 64'h0000_0042_0000_0000);

    repeat (10) @(negedge clk);
    check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    check("pending_miso", 64'(exp_rd_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
